// File: rtl/pattern_pkg.sv
// Shared types and helpers for the pattern serializer and detector blocks.
package pattern_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

  localparam logic [4:0] DEFAULT_PATTERN = 5'b01101;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int len_width(input int w);
    return $clog2(w + 1);
  endfunction

  // A zero or oversized length means "the whole word".
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned width);
    return (len == 0 || len > width) ? width : len;
  endfunction

endpackage

// File: rtl/pattern_word_fifo.sv
// Synchronous FIFO holding {word, effective_len} entries for the serializer.
module pattern_word_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [W-1:0]                 push_data,
  input  logic                         pop,
  output logic [W-1:0]                 pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pattern_bit_serializer.sv
// Buffers parallel words and shifts them out MSB-first as a registered bit stream.
module pattern_bit_serializer
  import pattern_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WIDTH-1:0]              word_i,
  input  logic [len_width(WIDTH)-1:0]   len_i,
  input  logic                          word_valid_i,
  output logic                          word_ready_o,
  input  logic                          hold_i,
  output logic                          d_o,
  output logic                          v_o,
  output logic                          sof_o,
  output logic                          busy_o
);
  localparam int LENW = len_width(WIDTH);
  localparam int CW   = $clog2(DEPTH + 1);

  state_t             state;
  logic [WIDTH-1:0]   shreg, pop_word;
  logic [LENW-1:0]    remaining, pop_len, len_eff;
  logic               first, pop, full, empty;
  logic [CW-1:0]      count;
  logic [WIDTH+LENW-1:0] pop_data;

  assign len_eff      = LENW'(clamp_len(32'(len_i), WIDTH));
  assign word_ready_o = !full;
  assign {pop_word, pop_len} = pop_data;

  // Pop on load from IDLE, or on the last bit so words chain with no bubble.
  assign pop = !empty && ((state == IDLE) ||
                          (state == SHIFT && !hold_i && remaining == LENW'(1)));

  assign busy_o = (count != '0) || (state == SHIFT) || v_o;

  pattern_word_fifo #(.W(WIDTH + LENW), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (word_valid_i),
    .push_data ({word_i, len_eff}),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      remaining <= '0;
      first     <= 1'b0;
      d_o       <= 1'b0;
      v_o       <= 1'b0;
      sof_o     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          v_o   <= 1'b0;
          sof_o <= 1'b0;
          if (pop) begin
            shreg     <= pop_word;
            remaining <= pop_len;
            first     <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (hold_i) begin
            v_o   <= 1'b0;
            sof_o <= 1'b0;
          end else begin
            d_o   <= shreg[WIDTH-1];
            v_o   <= 1'b1;
            sof_o <= first;
            first <= 1'b0;
            if (remaining == LENW'(1)) begin
              if (pop) begin
                shreg     <= pop_word;
                remaining <= pop_len;
                first     <= 1'b1;
              end else begin
                state <= IDLE;
              end
            end else begin
              shreg     <= shreg << 1;
              remaining <= remaining - LENW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_bit_serializer.sv
// Directed and random checks of the serializer against a queue-of-bits reference.
module tb_pattern_bit_serializer;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  word_i = '0;
  logic [LW-1:0] len_i = '0;
  logic          word_valid_i = 1'b0;
  logic          word_ready_o;
  logic          hold_i = 1'b0;
  logic          d_o, v_o, sof_o, busy_o;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {bit d; bit sof;} bit_t;
  bit_t q[$];
  bit_t exp_b;
  int   nb;

  pattern_bit_serializer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk          (clk),
    .rst          (rst),
    .word_i       (word_i),
    .len_i        (len_i),
    .word_valid_i (word_valid_i),
    .word_ready_o (word_ready_o),
    .hold_i       (hold_i),
    .d_o          (d_o),
    .v_o          (v_o),
    .sof_o        (sof_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: each accepted word becomes its effective bits, MSB first.
  always @(negedge clk) begin
    if (rst) q.delete();
    else begin
      if (v_o) begin
        if (q.size() == 0) chk("extra_bit", 1, 0);
        else begin
          exp_b = q.pop_front();
          chk("d_o", d_o, exp_b.d);
          chk("sof_o", sof_o, exp_b.sof);
        end
      end
      if (word_valid_i && word_ready_o) begin
        nb = (len_i == 0 || len_i > W) ? W : int'(len_i);
        for (int i = 0; i < nb; i++) q.push_back('{d: word_i[W-1-i], sof: (i == 0)});
      end
    end
  end

  task automatic push(input logic [W-1:0] w, input int l);
    bit ok = 0;
    word_i = w; len_i = LW'(l); word_valid_i = 1'b1;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = word_ready_o;
    end
    if (!ok) chk("push_timeout", 0, 1);
    @(posedge clk); #1;
    word_valid_i = 1'b0;
  endtask

  task automatic wait_v();
    bit ok = 0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = v_o;
    end
    if (!ok) chk("wait_v_timeout", 0, 1);
  endtask

  task automatic run_len(output int n);
    wait_v();
    n = 1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!v_o) break;
      n++;
    end
  endtask

  task automatic drain(input string tag);
    bit done = 0;
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge clk);
      done = !busy_o && !v_o;
    end
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_left"}, q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // reset state
    @(negedge clk);
    chk("rst_v", v_o, 0); chk("rst_d", d_o, 0); chk("rst_sof", sof_o, 0); chk("rst_busy", busy_o, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", word_ready_o, 1); chk("rst_busy2", busy_o, 0);
    @(posedge clk); #1;

    // single 5-bit word, exact latency
    push(8'b0110_1000, 5);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("lat_v%0d", i), v_o, (i >= 2 && i <= 6));
      if (i == 6) chk("lat_busy_last", busy_o, 1);
    end
    chk("lat_busy_after", busy_o, 0);
    @(posedge clk); #1;

    // back-to-back words, no bubble
    push(8'hA5, 8);
    push(8'hF0, 4);
    run_len(n);
    chk("b2b_run", n, 12);
    drain("b2b");

    // hold after 2nd bit
    push(8'hC3, 8);
    wait_v();
    @(negedge clk);
    chk("hold_bit2", v_o, 1);
    #1 hold_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("hold_bubble%0d", i), v_o, 0);
    end
    #1 hold_i = 1'b0;
    @(negedge clk);
    chk("hold_resume", v_o, 1);
    drain("hold");

    // fill FIFO under hold
    hold_i = 1'b1;
    push(8'hB0, 4);
    for (int i = 0; i < 4; i++) push(W'($urandom), 8);
    @(negedge clk);
    chk("fill_ready", word_ready_o, 0);
    chk("fill_v", v_o, 0);
    #1 hold_i = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("fill_ready_k%0d", k), word_ready_o, (k >= 4));
    end
    drain("fill");

    // len 0 means full width
    push(8'h81, 0);
    run_len(n);
    chk("len0_run", n, 8);
    drain("len0");

    // reset mid-word with two words queued
    push(8'hFF, 8);
    push(8'h55, 8);
    push(8'hAA, 8);
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("mid_bit3", v_o, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_v", v_o, 0); chk("mid_sof", sof_o, 0); chk("mid_busy", busy_o, 0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_ready", word_ready_o, 1);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (v_o) n++;
    end
    chk("mid_silent", n, 0);
    @(posedge clk); #1;

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      word_valid_i = 1'($urandom % 2);
      word_i       = W'($urandom);
      len_i        = LW'($urandom % 16);
      hold_i       = ($urandom % 4 == 0);
      @(posedge clk); #1;
    end
    word_valid_i = 1'b0;
    hold_i = 1'b0;
    drain("rand");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
